// File: rtl/id_stage_pipe.sv
// Decode stage for the 16-bit ISA: register file with WB write-through, branch
// resolution in ID, load-use hazard stall, and a valid/ready ID/EX register.
module id_stage_pipe #(
  parameter int DATA_W    = 16,
  parameter bit R0_ZERO   = 1'b1,
  parameter bit BYPASS_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       in_instr,
  input  logic [DATA_W-1:0] in_pc,
  input  logic [2:0]        flags,
  input  logic              ex_mem_read,
  input  logic [3:0]        ex_rd,
  input  logic              wb_we,
  input  logic [3:0]        wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_pc,
  output logic [DATA_W-1:0] out_rs1_data,
  output logic [DATA_W-1:0] out_rs2_data,
  output logic [DATA_W-1:0] out_imm,
  output logic [3:0]        out_rs1,
  output logic [3:0]        out_rs2,
  output logic [3:0]        out_rd,
  output logic [6:0]        out_ex_ctrl,
  output logic [1:0]        out_mem_ctrl,
  output logic [1:0]        out_wb_ctrl,
  output logic              branch_taken,
  output logic [DATA_W-1:0] branch_target,
  output logic              halted
);

  localparam logic [3:0] OP_LW  = 4'h8;
  localparam logic [3:0] OP_SW  = 4'h9;
  localparam logic [3:0] OP_LLB = 4'hA;
  localparam logic [3:0] OP_LHB = 4'hB;
  localparam logic [3:0] OP_B   = 4'hC;
  localparam logic [3:0] OP_BR  = 4'hD;
  localparam logic [3:0] OP_PCS = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;
  localparam logic [DATA_W-1:0] PC_STEP = {{(DATA_W-2){1'b0}}, 2'b10};

  typedef enum logic [0:0] {ST_RUN = 1'b0, ST_HALT = 1'b1} state_t;

  state_t            state_r;
  state_t            state_nxt_s;
  logic [DATA_W-1:0] regs_r [16];

  logic [3:0]        op_s, fa_s, fb_s, fc_s;
  logic [3:0]        rs1_s, rs2_s;
  logic [DATA_W-1:0] rs1_data_s, rs2_data_s, imm_s;
  logic              alu_src_s, reg_dst_s, pcs_s;
  logic              mem_read_s, mem_write_s, mem_to_reg_s, reg_write_s;
  logic              use_rs1_s, use_rs2_s, is_branch_s, is_hlt_s;
  logic              hazard_s, cond_s, accept_s;

  assign op_s = in_instr[15:12];
  assign fa_s = in_instr[11:8];
  assign fb_s = in_instr[7:4];
  assign fc_s = in_instr[3:0];

  // Source read: R0 hard-wired zero wins over a same-cycle WB write to R0.
  function automatic logic [DATA_W-1:0] src_read(
    input logic [3:0]        idx,
    input logic [DATA_W-1:0] stored,
    input logic              we,
    input logic [3:0]        wrd,
    input logic [DATA_W-1:0] wdata
  );
    logic [DATA_W-1:0] v;
    if (R0_ZERO && (idx == 4'd0)) begin
      v = {DATA_W{1'b0}};
    end else if (BYPASS_EN && we && (wrd == idx)) begin
      v = wdata;
    end else begin
      v = stored;
    end
    return v;
  endfunction

  // Opcode decode into control bits, immediate and which sources are really read
  always_comb begin
    alu_src_s    = 1'b0;
    reg_dst_s    = 1'b0;
    pcs_s        = 1'b0;
    mem_read_s   = 1'b0;
    mem_write_s  = 1'b0;
    mem_to_reg_s = 1'b0;
    reg_write_s  = 1'b0;
    use_rs1_s    = 1'b0;
    use_rs2_s    = 1'b0;
    is_branch_s  = 1'b0;
    is_hlt_s     = 1'b0;
    imm_s        = {DATA_W{1'b0}};
    case (op_s)
      4'h0, 4'h1, 4'h2, 4'h3, 4'h7: begin
        reg_dst_s   = 1'b1;
        reg_write_s = 1'b1;
        use_rs1_s   = 1'b1;
        use_rs2_s   = 1'b1;
      end
      4'h4, 4'h5, 4'h6: begin
        alu_src_s   = 1'b1;
        reg_write_s = 1'b1;
        use_rs1_s   = 1'b1;
        imm_s       = {{(DATA_W-4){fc_s[3]}}, fc_s};
      end
      OP_LW: begin
        mem_read_s   = 1'b1;
        mem_to_reg_s = 1'b1;
        reg_write_s  = 1'b1;
        use_rs1_s    = 1'b1;
        imm_s        = {{(DATA_W-5){fc_s[3]}}, fc_s, 1'b0};
      end
      OP_SW: begin
        mem_write_s = 1'b1;
        use_rs1_s   = 1'b1;
        use_rs2_s   = 1'b1;
        imm_s       = {{(DATA_W-5){fc_s[3]}}, fc_s, 1'b0};
      end
      OP_LLB, OP_LHB: begin
        reg_write_s = 1'b1;
        use_rs1_s   = 1'b1;
        imm_s       = {{(DATA_W-8){1'b0}}, in_instr[7:0]};
      end
      OP_B: begin
        is_branch_s = 1'b1;
      end
      OP_BR: begin
        is_branch_s = 1'b1;
        use_rs1_s   = 1'b1;
      end
      OP_PCS: begin
        pcs_s       = 1'b1;
        reg_write_s = 1'b1;
      end
      OP_HLT: begin
        is_hlt_s = 1'b1;
      end
      default: begin
        is_hlt_s = 1'b0;
      end
    endcase
  end

  // Register selection and read with write-through
  always_comb begin
    if ((op_s == OP_LLB) || (op_s == OP_LHB)) begin
      rs1_s = fa_s;
    end else begin
      rs1_s = fb_s;
    end
    if (op_s == OP_SW) begin
      rs2_s = fa_s;
    end else if (reg_dst_s) begin
      rs2_s = fc_s;
    end else begin
      rs2_s = fb_s;
    end
    rs1_data_s = src_read(rs1_s, regs_r[rs1_s], wb_we, wb_rd, wb_data);
    rs2_data_s = src_read(rs2_s, regs_r[rs2_s], wb_we, wb_rd, wb_data);
  end

  // Load-use hazard: only sources the opcode consumes can stall
  always_comb begin
    hazard_s = 1'b0;
    if (ex_mem_read && ((ex_rd != 4'd0) || !R0_ZERO)) begin
      hazard_s = (use_rs1_s && (ex_rd == rs1_s)) || (use_rs2_s && (ex_rd == rs2_s));
    end else begin
      hazard_s = 1'b0;
    end
  end

  assign in_ready = !halted && !hazard_s && (!out_valid || out_ready);
  assign accept_s = in_valid && in_ready;

  // Branch condition from {Z,V,N} and the ccc field
  always_comb begin
    case (in_instr[11:9])
      3'b000:  cond_s = !flags[2];
      3'b001:  cond_s = flags[2];
      3'b010:  cond_s = !flags[2] && !flags[0];
      3'b011:  cond_s = flags[0];
      3'b100:  cond_s = flags[2] || (!flags[2] && !flags[0]);
      3'b101:  cond_s = flags[0] || flags[2];
      3'b110:  cond_s = flags[1];
      3'b111:  cond_s = 1'b1;
      default: cond_s = 1'b0;
    endcase
  end

  // Branch redirect; target is meaningful only alongside branch_taken
  always_comb begin
    branch_taken = accept_s && is_branch_s && cond_s;
    if (op_s == OP_B) begin
      branch_target = in_pc + PC_STEP + {{(DATA_W-10){in_instr[8]}}, in_instr[8:0], 1'b0};
    end else begin
      branch_target = rs1_data_s;
    end
  end

  // Register file write port
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) begin
        regs_r[i] <= {DATA_W{1'b0}};
      end
    end else if (wb_we && !(R0_ZERO && (wb_rd == 4'd0))) begin
      regs_r[wb_rd] <= wb_data;
    end
  end

  // ID/EX pipeline register: load on accept, bubble when drained, otherwise hold
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid    <= 1'b0;
      out_pc       <= {DATA_W{1'b0}};
      out_rs1_data <= {DATA_W{1'b0}};
      out_rs2_data <= {DATA_W{1'b0}};
      out_imm      <= {DATA_W{1'b0}};
      out_rs1      <= 4'd0;
      out_rs2      <= 4'd0;
      out_rd       <= 4'd0;
      out_ex_ctrl  <= 7'd0;
      out_mem_ctrl <= 2'd0;
      out_wb_ctrl  <= 2'd0;
    end else if (accept_s) begin
      out_valid    <= 1'b1;
      out_pc       <= in_pc;
      out_rs1_data <= rs1_data_s;
      out_rs2_data <= rs2_data_s;
      out_imm      <= imm_s;
      out_rs1      <= rs1_s;
      out_rs2      <= rs2_s;
      out_rd       <= fa_s;
      out_ex_ctrl  <= {pcs_s, alu_src_s, reg_dst_s, op_s};
      out_mem_ctrl <= {mem_read_s, mem_write_s};
      out_wb_ctrl  <= {mem_to_reg_s, reg_write_s};
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end else begin
      out_valid <= out_valid;
    end
  end

  // RUN/HALT state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_RUN;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // HALT is entered on an accepted HLT and left only through reset
  always_comb begin
    case (state_r)
      ST_RUN: begin
        if (accept_s && is_hlt_s) begin
          state_nxt_s = ST_HALT;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_HALT: state_nxt_s = ST_HALT;
      default: state_nxt_s = ST_RUN;
    endcase
  end

  // State outputs
  always_comb begin
    halted = (state_r == ST_HALT);
  end

endmodule

// File: tb/tb_id_stage_pipe.sv
// Randomized scoreboard bench for id_stage_pipe: directed scenarios then random traffic,
// with a spec-level reference model and a monitor checking the ID/EX register.
module tb_id_stage_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_instr = 16'h0000;
  logic [15:0] in_pc = 16'h0000;
  logic [2:0]  flags = 3'b000;
  logic        ex_mem_read = 1'b0;
  logic [3:0]  ex_rd = 4'd0;
  logic        wb_we = 1'b0;
  logic [3:0]  wb_rd = 4'd0;
  logic [15:0] wb_data = 16'h0000;
  logic        out_ready = 1'b1;
  logic        out_valid;
  logic [15:0] out_pc, out_rs1_data, out_rs2_data, out_imm;
  logic [3:0]  out_rs1, out_rs2, out_rd;
  logic [6:0]  out_ex_ctrl;
  logic [1:0]  out_mem_ctrl, out_wb_ctrl;
  logic        branch_taken;
  logic [15:0] branch_target;
  logic        halted;

  id_stage_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .flags(flags),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .out_ready(out_ready), .out_valid(out_valid), .out_pc(out_pc),
    .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data), .out_imm(out_imm),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
    .out_ex_ctrl(out_ex_ctrl), .out_mem_ctrl(out_mem_ctrl), .out_wb_ctrl(out_wb_ctrl),
    .branch_taken(branch_taken), .branch_target(branch_target), .halted(halted)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] rs1_data;
    logic [15:0] rs2_data;
    logic [15:0] imm;
    logic [3:0]  rs1;
    logic [3:0]  rs2;
    logic [3:0]  rd;
    logic [6:0]  ex;
    logic [1:0]  mem;
    logic [1:0]  wb;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] regs_m [16];
  bit          valid_m = 1'b0;
  bit          halted_m = 1'b0;
  int          checks = 0;
  int          failures = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic int sext(input int v, input int bits);
    return (v >= (1 << (bits - 1))) ? v - (1 << bits) : v;
  endfunction

  // Register read as software sees it: R0 is zero, a WB write this cycle is visible.
  function automatic logic [15:0] rd_reg(input logic [3:0] r);
    if (r == 4'd0) return 16'h0000;
    if (wb_we && (wb_rd == r)) return wb_data;
    return regs_m[r];
  endfunction

  function automatic exp_t model_decode(input logic [15:0] ins, input logic [15:0] pc);
    exp_t e;
    int op, a, b, c;
    bit reg_dst, alu_src;
    op = int'(ins[15:12]); a = int'(ins[11:8]); b = int'(ins[7:4]); c = int'(ins[3:0]);
    alu_src = (op >= 4) && (op <= 6);
    reg_dst = (op <= 7) && !alu_src;
    e = '0;
    e.pc  = pc;
    e.rd  = 4'(a);
    e.rs1 = 4'((op == 10 || op == 11) ? a : b);
    e.rs2 = 4'((op == 9) ? a : (reg_dst ? c : b));
    if (alu_src) e.imm = 16'(sext(c, 4));
    else if (op == 8 || op == 9) e.imm = 16'(sext(c, 4) * 2);
    else if (op == 10 || op == 11) e.imm = {8'h00, ins[7:0]};
    else e.imm = 16'h0000;
    e.rs1_data = rd_reg(e.rs1);
    e.rs2_data = rd_reg(e.rs2);
    e.ex  = {(op == 14), alu_src, reg_dst, ins[15:12]};
    e.mem = {(op == 8), (op == 9)};
    e.wb  = {(op == 8), (op <= 8 || op == 10 || op == 11 || op == 14)};
    return e;
  endfunction

  function automatic bit hazard_m(input logic [15:0] ins);
    int op, a, b, c, s1, s2;
    bit u1, u2;
    op = int'(ins[15:12]); a = int'(ins[11:8]); b = int'(ins[7:4]); c = int'(ins[3:0]);
    s1 = (op == 10 || op == 11) ? a : b;
    s2 = (op == 9) ? a : ((op <= 3 || op == 7) ? c : b);
    u1 = !(op == 12 || op == 14 || op == 15);
    u2 = (op <= 3 || op == 7 || op == 9);
    if (!ex_mem_read || ex_rd == 4'd0) return 1'b0;
    return (u1 && int'(ex_rd) == s1) || (u2 && int'(ex_rd) == s2);
  endfunction

  function automatic bit cond_m(input logic [2:0] ccc);
    bit z, v, n;
    z = flags[2]; v = flags[1]; n = flags[0];
    case (ccc)
      3'd0: return !z;
      3'd1: return z;
      3'd2: return !z && !n;
      3'd3: return n;
      3'd4: return z || (!z && !n);
      3'd5: return n || z;
      3'd6: return v;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [15:0] target_m(input logic [15:0] ins, input logic [15:0] pc);
    if (ins[15:12] == 4'hC) return 16'(int'(pc) + 2 + 2 * sext(int'(ins[8:0]), 9));
    return rd_reg(ins[7:4]);
  endfunction

  // One clock: check handshake/branch outputs mid-cycle, then advance the model.
  task automatic step();
    bit exp_rdy, acc_m, exp_bt;
    logic [3:0] op;
    @(negedge clk);
    op = in_instr[15:12];
    exp_rdy = !halted_m && !hazard_m(in_instr) && (!valid_m || out_ready);
    acc_m = in_valid && exp_rdy;
    exp_bt = acc_m && (op == 4'hC || op == 4'hD) && cond_m(in_instr[11:9]);
    chk("in_ready", 128'(in_ready), 128'(exp_rdy));
    chk("out_valid", 128'(out_valid), 128'(valid_m));
    chk("halted", 128'(halted), 128'(halted_m));
    chk("branch_taken", 128'(branch_taken), 128'(exp_bt));
    if (exp_bt) chk("branch_target", 128'(branch_target), 128'(target_m(in_instr, in_pc)));
    if (acc_m) sb.push_back(model_decode(in_instr, in_pc));
    @(posedge clk);
    if (acc_m) begin
      valid_m = 1'b1;
      if (op == 4'hF) halted_m = 1'b1;
    end else if (out_ready) begin
      valid_m = 1'b0;
    end
    if (wb_we && wb_rd != 4'd0) regs_m[wb_rd] = wb_data;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; wb_we = 1'b0; ex_mem_read = 1'b0; out_ready = 1'b1;
    sb.delete(); valid_m = 1'b0; halted_m = 1'b0;
    for (int i = 0; i < 16; i++) regs_m[i] = 16'h0000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_state", 128'({out_valid, halted, out_pc, out_rs1_data, out_rs2_data, out_imm,
        out_rs1, out_rs2, out_rd, out_ex_ctrl, out_mem_ctrl, out_wb_ctrl}), 128'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Monitor: whenever ID/EX holds an instruction it must match the oldest expectation
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (sb.size() == 0) begin
        chk("idex_unexpected", 128'(out_valid), 128'd0);
      end else begin
        chk("idex", 128'({out_pc, out_rs1_data, out_rs2_data, out_imm, out_rs1, out_rs2, out_rd,
            out_ex_ctrl, out_mem_ctrl, out_wb_ctrl}), 128'(sb[0]));
        if (out_ready) void'(sb.pop_front());
      end
    end
  end

  initial begin
    logic [3:0] op;
    do_reset();

    // write R3 then ADD R1,R3,R3
    wb_we = 1'b1; wb_rd = 4'd3; wb_data = 16'h1234; step();
    wb_we = 1'b0; in_valid = 1'b1; in_instr = 16'h0133; in_pc = 16'h0000; step();
    in_valid = 1'b0; step();
    // load-use stall on R3, then release
    ex_mem_read = 1'b1; ex_rd = 4'd3; in_valid = 1'b1; in_pc = 16'h0002; step(); step();
    ex_mem_read = 1'b0; step();
    in_valid = 1'b0; step();
    // same-cycle bypass into SW data, then R0 write ignored
    wb_we = 1'b1; wb_rd = 4'd5; wb_data = 16'hBEEF; in_valid = 1'b1;
    in_instr = 16'h9522; in_pc = 16'h0004; step();
    wb_rd = 4'd0; wb_data = 16'hFFFF; in_valid = 1'b0; step();
    wb_we = 1'b0; in_valid = 1'b1; in_instr = 16'h0100; step();
    // B EQ backwards, taken then not taken; BR always through R3
    in_pc = 16'h0010; in_instr = 16'hC3FE; flags = 3'b100; step();
    flags = 3'b000; step();
    in_instr = 16'hDE30; step();
    // back-pressure hold, then release
    out_ready = 1'b0; in_instr = 16'h1133; repeat (4) step();
    out_ready = 1'b1; in_instr = 16'h2233; step();
    in_valid = 1'b0; step(); step();

    for (int k = 0; k < 1500; k++) begin
      op = 4'($urandom_range(0, 14));
      in_valid = ($urandom_range(0, 3) != 0);
      in_instr = {op, 12'($urandom)};
      in_pc = {15'($urandom), 1'b0};
      flags = 3'($urandom);
      wb_we = 1'($urandom);
      wb_rd = 4'($urandom);
      wb_data = 16'($urandom);
      ex_mem_read = ($urandom_range(0, 3) == 0);
      ex_rd = 4'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end

    // HLT, stuck while halted, reset mid-HALT drops the in-flight instruction
    in_valid = 1'b0; wb_we = 1'b0; ex_mem_read = 1'b0; out_ready = 1'b1; step(); step();
    in_valid = 1'b1; in_instr = 16'hF000; in_pc = 16'h0100; step();
    in_instr = 16'h0133; out_ready = 1'b0; repeat (3) step();
    do_reset();
    in_valid = 1'b1; in_instr = 16'h0133; step();
    in_valid = 1'b0; step(); step();
    chk("sb_drained", 128'(sb.size()), 128'(valid_m));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
